// File: rtl/led_status_if.sv
// Signal bundle between the classifier/heartbeat sources and the LED status stage.
interface led_status_if #(
    parameter int CLASS_W = 4
);
    logic               heartbeat_in;
    logic               start;
    logic               result_valid;
    logic [CLASS_W-1:0] result_class;
    logic               error;
    logic               clear;
    logic [9:0]         LEDR;

    modport master (
        output heartbeat_in, start, result_valid, result_class, error, clear,
        input  LEDR
    );

    modport slave (
        input  heartbeat_in, start, result_valid, result_class, error, clear,
        output LEDR
    );
endinterface

// File: rtl/led_status_ctrl.sv
// Board status-display stage: heartbeat, busy blink, latched result class,
// completed-result count and fault pattern on the 10 board LEDs.
//
// state | meaning
// IDLE  | display dark except heartbeat
// BUSY  | classification running, LEDR[7] blinks
// DONE  | result shown: stretch flag, count, latched class
// FAULT | all of LEDR[7:0] blink, only clear exits
module led_status_ctrl #(
    parameter int BLINK_CYCLES   = 12500000,
    parameter int STRETCH_CYCLES = 25000000,
    parameter int CLASS_W        = 4
) (
    input  logic       clock,
    input  logic       reset,
    led_status_if.slave bus
);
    localparam int BLINK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} state_t;

    state_t             state_q, state_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [STRETCH_W-1:0] stretch_q, stretch_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic [1:0]         count_q, count_d;
    logic [9:0]         ledr_q, ledr_d;
    logic               entering;

    // State register and all display datapath registers, async active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            stretch_q   <= '0;
            class_q     <= '0;
            count_q     <= '0;
            ledr_q      <= '0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            stretch_q   <= stretch_d;
            class_q     <= class_d;
            count_q     <= count_d;
            ledr_q      <= ledr_d;
        end
    end

    // Next state by event priority, then the next blink/stretch/latch values and
    // the LED pattern they produce, so LEDR reflects the post-edge state directly.
    always_comb begin
        state_d     = state_q;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        stretch_d   = '0;
        class_d     = class_q;
        count_d     = count_q;
        ledr_d      = '0;

        if (bus.clear) begin
            state_d = IDLE;
        end else if (bus.error) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = BUSY;
                BUSY:    if (bus.result_valid) state_d = DONE;
                DONE:    if (bus.start) state_d = BUSY;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end

        entering = (state_d != state_q);

        if (state_q == BUSY && state_d == DONE) begin
            class_d = bus.result_class;
            count_d = count_q + 2'd1;
        end

        if (state_d == BUSY || state_d == FAULT) begin
            if (entering) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_d     = blink_q;
            end
        end

        if (state_d == DONE) begin
            if (entering) begin
                stretch_d = STRETCH_LOAD;
            end else if (stretch_q != '0) begin
                stretch_d = stretch_q - STRETCH_W'(1);
            end
        end

        ledr_d[9] = bus.heartbeat_in;
        case (state_d)
            BUSY:  ledr_d[7] = blink_d;
            DONE: begin
                ledr_d[6]           = (stretch_d != '0);
                ledr_d[5:4]         = count_d;
                ledr_d[CLASS_W-1:0] = class_d;
            end
            FAULT: ledr_d[7:0] = {8{blink_d}};
            default: ledr_d[7:0] = '0;
        endcase
    end

    assign bus.LEDR = ledr_q;
endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl: the driver pushes the expected LEDR for
// each clock edge, the monitor pops and compares just after that edge.
module tb_led_status_ctrl;
    localparam int BLINK   = 4;
    localparam int STRETCH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    led_status_if #(.CLASS_W(4)) bus ();

    led_status_ctrl #(
        .BLINK_CYCLES  (BLINK),
        .STRETCH_CYCLES(STRETCH),
        .CLASS_W       (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    logic [9:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int edge_no = 0;

    // Reference model: mode plus cycles spent in it; blink and stretch are
    // derived arithmetically from the time since entry.
    int m_mode = 0;   // 0 idle, 1 busy, 2 done, 3 fault
    int m_t    = 0;
    int m_cnt  = 0;
    int m_cls  = 0;

    task automatic cyc(input bit s, input bit rv, input int cls, input bit e,
                       input bit c, input bit rst);
        int nm;
        bit hb;
        logic [9:0] exp_v;
        @(negedge clock);
        hb = 1'($urandom_range(0, 1));
        bus.heartbeat_in = hb;
        bus.start        = s;
        bus.result_valid = rv;
        bus.result_class = 4'(cls);
        bus.error        = e;
        bus.clear        = c;
        reset            = rst;
        exp_v = '0;
        if (rst) begin
            m_mode = 0; m_t = 0; m_cnt = 0; m_cls = 0;
        end else begin
            nm = m_mode;
            if (c) nm = 0;
            else if (e) nm = 3;
            else if (m_mode == 1 && rv) nm = 2;
            else if ((m_mode == 0 || m_mode == 2) && s) nm = 1;
            if (m_mode == 1 && nm == 2) begin
                m_cnt = (m_cnt + 1) % 4;
                m_cls = cls;
            end
            m_t = (nm != m_mode) ? 0 : m_t + 1;
            m_mode = nm;
            exp_v[9] = hb;
            case (m_mode)
                1: exp_v[7] = ((m_t / BLINK) % 2 == 0);
                2: begin
                    exp_v[6]   = (m_t < STRETCH);
                    exp_v[5:4] = 2'(m_cnt);
                    exp_v[3:0] = 4'(m_cls);
                end
                3: exp_v[7:0] = ((m_t / BLINK) % 2 == 0) ? 8'hFF : 8'h00;
                default: exp_v[7:0] = 8'h00;
            endcase
        end
        exp_q.push_back(exp_v);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: LEDR is a new output after every edge; compare against the queue.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clock);
            #1;
            edge_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.LEDR === e) passes++;
                else $display("FAIL ledr edge %0d: got %03h expected %03h", edge_no, bus.LEDR, e);
            end
        end
    end

    initial begin
        int guard;
        bus.heartbeat_in = 1'b0;
        bus.start        = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_class = 4'h0;
        bus.error        = 1'b0;
        bus.clear        = 1'b0;

        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        idle(2);
        cyc(0, 1, 5, 0, 0, 0);          // result_valid in IDLE ignored
        idle(2);
        cyc(1, 0, 0, 0, 0, 0);          // busy blink
        idle(10);
        cyc(0, 1, 10, 0, 0, 0);         // class A, count 1
        idle(12);
        for (int r = 0; r < 3; r++) begin
            cyc(1, 0, 0, 0, 0, 0);
            idle(2);
            cyc(0, 1, $urandom_range(0, 15), 0, 0, 0);
            idle(3);
        end
        cyc(0, 0, 0, 0, 1, 0);          // clear keeps count
        idle(2);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 3, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 1, 0, 0);          // error in DONE
        for (int k = 0; k < 10; k++)
            cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 7, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);          // clear beats error
        idle(2);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 9, 1, 0, 0);          // error beats result_valid
        idle(3);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(2);

        // Asynchronous reset mid-BUSY: LEDR must clear before any clock edge.
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.LEDR === 10'h000) passes++;
        else $display("FAIL async_reset: got %03h expected 000", bus.LEDR);
        repeat (2) cyc(0, 0, 0, 0, 0, 1);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 15), $urandom_range(0, 39) == 0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
        end
        idle(1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
